// File: rtl/nn_sng_pkg.sv
// Shared types and constants for the frame-based stochastic number generator.
package nn_sng_pkg;

  typedef enum logic {
    StIdle = 1'b0,
    StRun  = 1'b1
  } sng_state_e;

  localparam int unsigned MinWidth = 4;
  localparam int unsigned MaxWidth = 16;

  // Right-shifting Galois feedback masks of primitive polynomials, one per width.
  localparam logic [15:0] LfsrTaps [MinWidth:MaxWidth] = '{
    16'h000C, 16'h0014, 16'h0030, 16'h0060, 16'h00B8, 16'h0110, 16'h0240,
    16'h0500, 16'h0E08, 16'h1C80, 16'h3802, 16'h6000, 16'hD008
  };

endpackage

// File: rtl/nn_lfsr.sv
// Maximal-length Galois LFSR with synchronous seed load and step enable.
module nn_lfsr
  import nn_sng_pkg::*;
#(
  parameter int unsigned        WIDTH   = 8,
  parameter logic [WIDTH-1:0]   RST_VAL = {{(WIDTH-1){1'b0}}, 1'b1}
) (
  input  logic             CLK,
  input  logic             INIT_N,
  input  logic             LOAD,
  input  logic             STEP,
  input  logic [WIDTH-1:0] SEED,
  output logic [WIDTH-1:0] Q
);

  localparam logic [WIDTH-1:0] Taps = LfsrTaps[WIDTH][WIDTH-1:0];

  logic [WIDTH-1:0] q_d, q_q;

  // Load wins over step so a new frame always starts from the seed.
  always_comb begin
    q_d = q_q;
    if (LOAD) begin
      q_d = SEED;
    end else if (STEP) begin
      q_d = {1'b0, q_q[WIDTH-1:1]} ^ (q_q[0] ? Taps : '0);
    end
  end

  always_ff @(posedge CLK or negedge INIT_N) begin
    if (!INIT_N) begin
      q_q <= RST_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign Q = q_q;

endmodule

// File: rtl/nn_sng_frame.sv
// Stochastic number generator emitting frames of 2^WIDTH-1 bits with exactly IN_VAL ones.
// Define NN_SNG_ONESCOUNT_EN to add the ONES_CNT output (ones count of the last frame).
module nn_sng_frame
  import nn_sng_pkg::*;
#(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH-1:0] SEED  = {{(WIDTH-1){1'b0}}, 1'b1}
) (
  input  logic             CLK,
  input  logic             INIT_N,
  input  logic [WIDTH-1:0] IN_VAL,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic             EN,
  output logic             OUT,
  output logic             OUT_VALID,
  output logic             FRAME_DONE
`ifdef NN_SNG_ONESCOUNT_EN
  ,
  output logic [WIDTH-1:0] ONES_CNT
`endif
);

  localparam logic [WIDTH-1:0] LastCnt = {{(WIDTH-1){1'b1}}, 1'b0};
  localparam logic [WIDTH-1:0] One     = {{(WIDTH-1){1'b0}}, 1'b1};

  sng_state_e       state_q;
  logic [WIDTH-1:0] prob_q;
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] lfsr_q;
  logic             out_q;
  logic             out_valid_q;
  logic             frame_done_q;

  logic last_bit;
  logic run_step;
  logic xfer;
  logic sc_bit;

  assign last_bit = (cnt_q == LastCnt);
  assign run_step = (state_q == StRun) && EN;
  // Accepting on the last bit lets the next frame follow with no bubble.
  assign IN_READY = (state_q == StIdle) || (run_step && last_bit);
  assign xfer     = IN_VALID && IN_READY;
  assign sc_bit   = (lfsr_q <= prob_q);

  nn_lfsr #(
    .WIDTH   (WIDTH),
    .RST_VAL (SEED)
  ) u_lfsr (
    .CLK    (CLK),
    .INIT_N (INIT_N),
    .LOAD   (xfer),
    .STEP   (run_step),
    .SEED   (SEED),
    .Q      (lfsr_q)
  );

  always_ff @(posedge CLK or negedge INIT_N) begin
    if (!INIT_N) begin
      state_q      <= StIdle;
      prob_q       <= '0;
      cnt_q        <= '0;
      out_q        <= 1'b0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      out_valid_q  <= run_step;
      frame_done_q <= run_step && last_bit;
      if (run_step) begin
        out_q <= sc_bit;
        cnt_q <= cnt_q + One;
        if (last_bit) begin
          state_q <= StIdle;
        end
      end
      // A transfer overrides the end-of-frame return to idle.
      if (xfer) begin
        prob_q  <= IN_VAL;
        cnt_q   <= '0;
        state_q <= StRun;
      end
    end
  end

  assign OUT        = out_q;
  assign OUT_VALID  = out_valid_q;
  assign FRAME_DONE = frame_done_q;

`ifdef NN_SNG_ONESCOUNT_EN
  logic [WIDTH-1:0] ones_acc_q;
  logic [WIDTH-1:0] ones_cnt_q;

  always_ff @(posedge CLK or negedge INIT_N) begin
    if (!INIT_N) begin
      ones_acc_q <= '0;
      ones_cnt_q <= '0;
    end else if (run_step) begin
      if (last_bit) begin
        ones_cnt_q <= ones_acc_q + {{(WIDTH-1){1'b0}}, sc_bit};
        ones_acc_q <= '0;
      end else begin
        ones_acc_q <= ones_acc_q + {{(WIDTH-1){1'b0}}, sc_bit};
      end
    end
  end

  assign ONES_CNT = ones_cnt_q;
`endif

endmodule

// File: tb/tb_nn_sng_frame.sv
// Self-checking bench for nn_sng_frame at WIDTH=8 against frame-level properties.
module tb_nn_sng_frame;

  localparam int W      = 8;
  localparam int N      = 255;
  localparam int SEED_V = 1;

  logic         CLK      = 1'b0;
  logic         INIT_N   = 1'b0;
  logic [W-1:0] IN_VAL   = '0;
  logic         IN_VALID = 1'b0;
  logic         EN       = 1'b0;
  logic         IN_READY;
  logic         OUT;
  logic         OUT_VALID;
  logic         FRAME_DONE;
`ifdef NN_SNG_ONESCOUNT_EN
  logic [W-1:0] ones_cnt;
`endif

  nn_sng_frame #(
    .WIDTH (W),
    .SEED  (8'd1)
  ) dut (
    .CLK        (CLK),
    .INIT_N     (INIT_N),
    .IN_VAL     (IN_VAL),
    .IN_VALID   (IN_VALID),
    .IN_READY   (IN_READY),
    .EN         (EN),
    .OUT        (OUT),
    .OUT_VALID  (OUT_VALID),
    .FRAME_DONE (FRAME_DONE)
`ifdef NN_SNG_ONESCOUNT_EN
    ,
    .ONES_CNT   (ones_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic en_edge = 1'b0;
  logic out_prev = 1'b0;
  int stall_viol = 0;
  int hold_viol = 0;

  logic bits_log[$];
  int   vcyc_log[$];
  int   fd_log[$];
  int         frame_prob[$];
  logic [N-1:0] frame_vec[$];
  logic [N-1:0] ref100 = '0;

  always @(posedge CLK) begin
    cyc++;
    en_edge = EN;
  end

  // Log every valid bit, the bit index of every FRAME_DONE, and stall behaviour.
  always @(negedge CLK) begin
    if (INIT_N) begin
      if (OUT_VALID) begin
        bits_log.push_back(OUT);
        vcyc_log.push_back(cyc);
      end
      if (FRAME_DONE) fd_log.push_back(bits_log.size());
      if (!en_edge && OUT_VALID) stall_viol++;
      if (!en_edge && OUT !== out_prev) hold_viol++;
    end
    out_prev = OUT;
  end

  // en_mode 0: EN always 1; 1: EN alternates; 2: EN random (mostly high).
  task automatic drive(input int p0, input int p1, input int nfr, input int en_mode,
                       input int stop_bits, output int acc_cyc, output bit tmo);
    int acc = 0;
    int budget = 0;
    int base_fd = fd_log.size();
    int base_bits = bits_log.size();
    bit xfer_now;
    tmo = 1'b0;
    acc_cyc = -1;
    IN_VAL = p0[W-1:0];
    IN_VALID = 1'b1;
    while (1) begin
      case (en_mode)
        0: EN = 1'b1;
        1: EN = ~EN;
        default: EN = ($urandom_range(0, 3) != 0);
      endcase
      #1;
      xfer_now = IN_VALID && IN_READY;
      @(posedge CLK);
      #1;
      if (xfer_now) begin
        acc++;
        if (acc == 1) acc_cyc = cyc;
        if (acc < nfr) IN_VAL = p1[W-1:0];
        else IN_VALID = 1'b0;
      end
      budget++;
      if (stop_bits > 0 && bits_log.size() - base_bits >= stop_bits) break;
      if (fd_log.size() - base_fd >= nfr) break;
      if (budget > 4000) begin
        tmo = 1'b1;
        break;
      end
    end
    IN_VALID = 1'b0;
    EN = 1'b1;
  endtask

  task automatic test_reset();
    INIT_N = 1'b0;
    EN = 1'b0;
    #3;
    checks++;
    if (OUT !== 1'b0) begin errors++; $display("FAIL reset_out: got %b, expected 0", OUT); end
    checks++;
    if (OUT_VALID !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid: got %b, expected 0", OUT_VALID);
    end
    checks++;
    if (FRAME_DONE !== 1'b0) begin
      errors++; $display("FAIL reset_frame_done: got %b, expected 0", FRAME_DONE);
    end
    checks++;
    if (IN_READY !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b, expected 1", IN_READY);
    end
`ifdef NN_SNG_ONESCOUNT_EN
    checks++;
    if (ones_cnt !== '0) begin errors++; $display("FAIL reset_ones_cnt: got %0d, expected 0", ones_cnt); end
`endif
    @(posedge CLK);
    #3;
    INIT_N = 1'b1;
    @(posedge CLK);
    #1;
    checks++;
    if (IN_READY !== 1'b1 || OUT_VALID !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got ready=%b valid=%b, expected ready=1 valid=0",
               IN_READY, OUT_VALID);
    end
  endtask

  task automatic test_fixed_frames();
    for (int i = 0; i < 3; i++) begin
      int p, bb, fb, acc_cyc, ones;
      bit tmo;
      logic [N-1:0] vec;
      p = (i == 0) ? 0 : (i == 1) ? 255 : 100;
      bb = bits_log.size();
      fb = fd_log.size();
      drive(p, 0, 1, 0, 0, acc_cyc, tmo);
      checks++;
      if (tmo) begin errors++; $display("FAIL fixed_timeout: prob %0d never finished its frame", p); end
      checks++;
      if (bits_log.size() - bb != N) begin
        errors++; $display("FAIL fixed_len: got %0d bits, expected %0d", bits_log.size() - bb, N);
      end
      vec = '0;
      for (int k = 0; k < N; k++) if (bb + k < bits_log.size()) vec[k] = bits_log[bb + k];
      ones = $countones(vec);
      checks++;
      if (ones != p) begin errors++; $display("FAIL fixed_ones: got %0d, expected %0d", ones, p); end
      checks++;
      if (vec[0] !== (p >= SEED_V)) begin
        errors++; $display("FAIL fixed_first_bit: prob %0d got %b, expected %b", p, vec[0], p >= SEED_V);
      end
      checks++;
      if (fd_log.size() - fb != 1) begin
        errors++; $display("FAIL fixed_fd_count: got %0d, expected 1", fd_log.size() - fb);
      end else begin
        checks++;
        if (fd_log[fb] != bb + N) begin
          errors++; $display("FAIL fixed_fd_pos: got bit %0d, expected bit %0d", fd_log[fb] - bb, N);
        end
      end
      if (vcyc_log.size() > bb) begin
        checks++;
        if (vcyc_log[bb] != acc_cyc + 1) begin
          errors++;
          $display("FAIL fixed_latency: first valid %0d cycles after accept, expected 1",
                   vcyc_log[bb] - acc_cyc);
        end
      end
`ifdef NN_SNG_ONESCOUNT_EN
      checks++;
      if (ones_cnt != p[W-1:0]) begin
        errors++; $display("FAIL fixed_ones_cnt: got %0d, expected %0d", ones_cnt, p);
      end
`endif
      frame_prob.push_back(p);
      frame_vec.push_back(vec);
      if (p == 100) ref100 = vec;
      EN = 1'b0;
      @(posedge CLK);
      #1;
      checks++;
      if (IN_READY !== 1'b1 || OUT_VALID !== 1'b0 || FRAME_DONE !== 1'b0) begin
        errors++;
        $display("FAIL fixed_idle: got ready=%b valid=%b done=%b, expected 1 0 0",
                 IN_READY, OUT_VALID, FRAME_DONE);
      end
    end
  endtask

  task automatic test_en_toggle();
    int bb = bits_log.size();
    int fb = fd_log.size();
    int sv = stall_viol;
    int hv = hold_viol;
    int acc_cyc;
    bit tmo;
    logic [N-1:0] vec = '0;
    drive(100, 0, 1, 1, 0, acc_cyc, tmo);
    checks++;
    if (tmo) begin errors++; $display("FAIL toggle_timeout: frame never finished"); end
    checks++;
    if (bits_log.size() - bb != N) begin
      errors++; $display("FAIL toggle_len: got %0d bits, expected %0d", bits_log.size() - bb, N);
    end
    for (int k = 0; k < N; k++) if (bb + k < bits_log.size()) vec[k] = bits_log[bb + k];
    checks++;
    if (vec !== ref100) begin
      errors++; $display("FAIL toggle_seq: got %h, expected %h", vec, ref100);
    end
    checks++;
    if (stall_viol != sv) begin
      errors++; $display("FAIL toggle_stall_valid: got %0d valid-after-stall cycles, expected 0",
                         stall_viol - sv);
    end
    checks++;
    if (hold_viol != hv) begin
      errors++; $display("FAIL toggle_out_hold: got %0d changes during stall, expected 0", hold_viol - hv);
    end
    checks++;
    if (fd_log.size() - fb != 1) begin
      errors++; $display("FAIL toggle_fd_count: got %0d, expected 1", fd_log.size() - fb);
    end
    frame_prob.push_back(100);
    frame_vec.push_back(vec);
  endtask

  task automatic test_random_stall();
    for (int i = 0; i < 4; i++) begin
      int p, bb, fb, sv, hv, acc_cyc, ones;
      bit tmo;
      logic [N-1:0] vec;
      p = $urandom_range(0, 255);
      bb = bits_log.size();
      fb = fd_log.size();
      sv = stall_viol;
      hv = hold_viol;
      drive(p, 0, 1, 2, 0, acc_cyc, tmo);
      vec = '0;
      for (int k = 0; k < N; k++) if (bb + k < bits_log.size()) vec[k] = bits_log[bb + k];
      ones = $countones(vec);
      checks++;
      if (tmo || bits_log.size() - bb != N) begin
        errors++; $display("FAIL rand_len: prob %0d got %0d bits, expected %0d", p, bits_log.size() - bb, N);
      end
      checks++;
      if (ones != p) begin errors++; $display("FAIL rand_ones: got %0d, expected %0d", ones, p); end
      checks++;
      if (fd_log.size() - fb != 1 || stall_viol != sv || hold_viol != hv) begin
        errors++;
        $display("FAIL rand_ctrl: got fd=%0d stallv=%0d holdv=%0d, expected 1 0 0",
                 fd_log.size() - fb, stall_viol - sv, hold_viol - hv);
      end
      frame_prob.push_back(p);
      frame_vec.push_back(vec);
    end
  endtask

  task automatic test_back_to_back();
    int bb = bits_log.size();
    int fb = fd_log.size();
    int acc_cyc;
    bit tmo;
    logic [N-1:0] va = '0;
    logic [N-1:0] vb = '0;
    drive(37, 200, 2, 0, 0, acc_cyc, tmo);
    checks++;
    if (tmo || bits_log.size() - bb != 2 * N) begin
      errors++; $display("FAIL b2b_len: got %0d bits, expected %0d", bits_log.size() - bb, 2 * N);
    end
    for (int k = 0; k < N; k++) begin
      if (bb + k < bits_log.size()) va[k] = bits_log[bb + k];
      if (bb + N + k < bits_log.size()) vb[k] = bits_log[bb + N + k];
    end
    checks++;
    if ($countones(va) != 37) begin
      errors++; $display("FAIL b2b_ones_a: got %0d, expected 37", $countones(va));
    end
    checks++;
    if ($countones(vb) != 200) begin
      errors++; $display("FAIL b2b_ones_b: got %0d, expected 200", $countones(vb));
    end
    checks++;
    if (fd_log.size() - fb != 2) begin
      errors++; $display("FAIL b2b_fd_count: got %0d, expected 2", fd_log.size() - fb);
    end else begin
      checks++;
      if (fd_log[fb] != bb + N || fd_log[fb + 1] != bb + 2 * N) begin
        errors++; $display("FAIL b2b_fd_pos: got %0d,%0d, expected %0d,%0d",
                           fd_log[fb] - bb, fd_log[fb + 1] - bb, N, 2 * N);
      end
    end
    if (vcyc_log.size() >= bb + 2 * N) begin
      checks++;
      if (vcyc_log[bb + 2 * N - 1] - vcyc_log[bb] + 1 != 2 * N) begin
        errors++; $display("FAIL b2b_contiguous: got span %0d cycles, expected %0d",
                           vcyc_log[bb + 2 * N - 1] - vcyc_log[bb] + 1, 2 * N);
      end
    end
`ifdef NN_SNG_ONESCOUNT_EN
    checks++;
    if (ones_cnt != 8'd200) begin errors++; $display("FAIL b2b_ones_cnt: got %0d, expected 200", ones_cnt); end
`endif
    frame_prob.push_back(37);
    frame_vec.push_back(va);
    frame_prob.push_back(200);
    frame_vec.push_back(vb);
  endtask

  task automatic test_mid_reset();
    int fb0 = fd_log.size();
    int bb, fb, acc_cyc;
    bit tmo;
    logic [N-1:0] vec = '0;
    drive(150, 0, 1, 0, 40, acc_cyc, tmo);
    checks++;
    if (tmo) begin errors++; $display("FAIL mreset_timeout: 40 bits never produced"); end
    #2;
    INIT_N = 1'b0;
    #1;
    checks++;
    if (OUT !== 1'b0 || OUT_VALID !== 1'b0 || FRAME_DONE !== 1'b0) begin
      errors++; $display("FAIL mreset_async: got out=%b valid=%b done=%b, expected 0 0 0",
                         OUT, OUT_VALID, FRAME_DONE);
    end
    @(posedge CLK);
    #3;
    EN = 1'b0;
    INIT_N = 1'b1;
    @(posedge CLK);
    #1;
    checks++;
    if (IN_READY !== 1'b1 || OUT_VALID !== 1'b0) begin
      errors++; $display("FAIL mreset_ready: got ready=%b valid=%b, expected 1 0", IN_READY, OUT_VALID);
    end
    bb = bits_log.size();
    fb = fd_log.size();
    EN = 1'b1;
    repeat (300) @(posedge CLK);
    #1;
    checks++;
    if (fd_log.size() != fb0 || bits_log.size() != bb) begin
      errors++; $display("FAIL mreset_abort: got fd=%0d bits=%0d after abort, expected 0 0",
                         fd_log.size() - fb0, bits_log.size() - bb);
    end
    drive(60, 0, 1, 0, 0, acc_cyc, tmo);
    for (int k = 0; k < N; k++) if (bb + k < bits_log.size()) vec[k] = bits_log[bb + k];
    checks++;
    if (tmo || bits_log.size() - bb != N || $countones(vec) != 60 || fd_log.size() - fb != 1) begin
      errors++; $display("FAIL mreset_next_frame: got bits=%0d ones=%0d fd=%0d, expected %0d 60 1",
                         bits_log.size() - bb, $countones(vec), fd_log.size() - fb, N);
    end
    frame_prob.push_back(60);
    frame_vec.push_back(vec);
  endtask

  // Every frame thresholds the same seed-started state sequence, so frames nest by probability.
  task automatic test_threshold_order();
    for (int i = 0; i < frame_prob.size(); i++) begin
      for (int j = i + 1; j < frame_prob.size(); j++) begin
        int lo = (frame_prob[i] <= frame_prob[j]) ? i : j;
        int hi = (frame_prob[i] <= frame_prob[j]) ? j : i;
        checks++;
        if ((frame_vec[lo] & ~frame_vec[hi]) != '0) begin
          errors++; $display("FAIL threshold_nest: prob %0d has ones outside prob %0d, got %h",
                             frame_prob[lo], frame_prob[hi], frame_vec[lo] & ~frame_vec[hi]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_fixed_frames();
    test_en_toggle();
    test_random_stall();
    test_back_to_back();
    test_mid_reset();
    test_threshold_order();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nn_sng_frame.md
NN_SNG_FRAME -- requirements
Module: nn_sng_frame

Interface
REQ-001 SHALL have parameter WIDTH, default 8: probability word width (legal 4..16).
REQ-002 SHALL have parameter SEED, default 1: LFSR reload value. Nonzero, WIDTH bits.
REQ-003 SHALL have port CLK, input, 1: the single clock; all state on its rising edge.
REQ-004 SHALL have port INIT_N, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port IN_VAL, input, WIDTH: probability numerator; P = IN_VAL/(2^WIDTH-1).
REQ-006 SHALL have port IN_VALID, input, 1: IN_VAL offered.
REQ-007 SHALL have port IN_READY, output, 1: block accepts IN_VAL this cycle. Combinational from state, counter and EN.
REQ-008 SHALL have port EN, input, 1: advance enable; low stalls generation.
REQ-009 SHALL have port OUT, output, 1: registered stochastic bit.
REQ-010 SHALL have port OUT_VALID, output, 1: OUT carries a new bit this cycle.
REQ-011 SHALL have port FRAME_DONE, output, 1: one-cycle pulse coincident with the last bit of a frame.

Function
REQ-012 SHALL implement FSM states IDLE and RUN.
REQ-013 IN_READY SHALL be 1 in IDLE, independent of EN.
REQ-014 In RUN, IN_READY SHALL be 1 only when EN=1 and bit counter = 2^WIDTH-2 (last bit); otherwise 0.
REQ-015 Transfer SHALL occur when IN_VALID=1 and IN_READY=1; IN_VALID while IN_READY=0 SHALL be ignored.
REQ-016 On transfer SHALL register IN_VAL to PROB, load LFSR with SEED, clear bit counter, and enter or remain in RUN.
REQ-017 RUN cycle with EN=1 SHALL:
  - register OUT <= (LFSR <= PROB);
  - set OUT_VALID=1 in the next cycle;
  - step the maximal-length LFSR;
  - increment the bit counter.
REQ-018 RUN cycle with EN=0 SHALL hold LFSR, counter and PROB; OUT_VALID=0 next cycle; OUT holds its value.
REQ-019 Latency SHALL be: acceptance at cycle t with EN=1 gives first OUT_VALID at t+2.
REQ-020 Frame SHALL be exactly 2^WIDTH-1 bits. Over a frame the LFSR visits every nonzero state once, so the count of ones = PROB exactly: PROB=0 gives all zeros, PROB=2^WIDTH-1 gives all ones.
REQ-021 FRAME_DONE SHALL assert with OUT_VALID for the last bit of the frame.
REQ-022 After the last bit, with no transfer, FSM SHALL return to IDLE.
REQ-023 After the last bit, with a simultaneous transfer, the next frame SHALL start with no bubble: OUT_VALID stays continuous across the boundary.
REQ-024 In IDLE, OUT_VALID and FRAME_DONE SHALL be 0.

Reset
REQ-025 INIT_N=0 SHALL asynchronously force:
  - state IDLE;
  - OUT=0, OUT_VALID=0, FRAME_DONE=0;
  - PROB=0, LFSR=SEED, counter=0;
  - ONES_CNT=0 when present.
REQ-026 Reset mid-frame SHALL abort the frame with no FRAME_DONE; IN_READY=1 in the first cycle after deassertion.

Configuration
REQ-027 Macro NN_SNG_ONESCOUNT_EN defined SHALL add output port ONES_CNT, WIDTH bits. It carries the ones count of the last completed frame and updates in the cycle FRAME_DONE asserts.
REQ-028 Without NN_SNG_ONESCOUNT_EN, port ONES_CNT and its counter SHALL be absent; all other behaviour is identical.

Structure
REQ-029 Package nn_sng_pkg SHALL hold:
  - the FSM state typedef;
  - the maximal-length LFSR tap constant table indexed by WIDTH 4..16.
REQ-030 LFSR SHALL be sub-module nn_lfsr, with ports CLK, INIT_N, LOAD, STEP, SEED, Q.

Verification
REQ-031 WIDTH=8, IN_VAL=0, EN=1 -> 255 OUT_VALID bits all 0; FRAME_DONE once, on bit 255; then IDLE.
REQ-032 IN_VAL=255 -> 255 ones. IN_VAL=100 -> exactly 100 ones; ONES_CNT=100 when macro defined.
REQ-033 IN_VAL=37 then IN_VAL=200 offered back-to-back -> 510 contiguous OUT_VALID cycles with ones counts 37 and 200; two FRAME_DONE pulses.
REQ-034 IN_VAL=100 with EN toggling 1,0,1,0 -> OUT sequence identical to the EN=1 run; OUT_VALID=0 after each EN=0 cycle.
REQ-035 INIT_N pulsed low at bit 40 of a frame -> OUT=0 and OUT_VALID=0 immediately; no FRAME_DONE; IN_READY=1 after release.
REQ-036 IN_VALID held high mid-frame -> not accepted until the last bit; PROB unchanged during the frame.
